// File: rtl/mse_serial_master.sv
// Purpose : MSE serial bus initiator; turns one register read/write command into a serial frame and returns read data or a timeout.
// Latency : header (17 or 49 bit periods of 2*CLK_DIV clk) + SRDY wait (2-flop sync) + 32 bit periods on reads; rsp_valid on the first DONE cycle.
// Backpressure: cmd_ready only in IDLE, no queueing; rsp_valid is a 1-cycle pulse with no ready (host must always take it).
//
// Ports:
//   clk, reset_n                    system clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (accept when both high)
//   cmd_write, cmd_addr, cmd_wdata  command fields, latched on accept
//   rsp_valid, rsp_rdata,           response pulse; rdata is 0 for writes and timeouts and is held
//   rsp_timeout                     until the next response; timeout marks a missing SRDY
//   busy                            high from accept until the FSM is back in IDLE
//   mse_sclk, mse_sle, mse_sdi      serial clock (idles low), frame enable, master->slave data
//   mse_sdo, mse_srdy               slave->master data and ready, both 2-flop synchronised
module mse_serial_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  mse_sclk,
  output logic                  mse_sle,
  output logic                  mse_sdi,
  input  logic                  mse_sdo,
  input  logic                  mse_srdy
);

  localparam int HDR_MAX = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int BCW     = $clog2(HDR_MAX + 1);
  localparam int PCW     = $clog2(CLK_DIV + 1);
  localparam int TCW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_OUT,
    S_WAIT_RDY,
    S_SHIFT_IN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PCW-1:0]        phase_q, phase_d;     // clk count within the current SCLK half-period
  logic [BCW-1:0]        bit_q, bit_d;         // bit index within the current shift phase
  logic [TCW-1:0]        wait_q, wait_d;       // cycles spent in WAIT_RDY
  logic [HDR_MAX-1:0]    shreg_q, shreg_d;     // outgoing header, MSB-aligned
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rin_q, rin_d;         // incoming read data
  logic                  sclk_q, sclk_d;
  logic                  sle_q, sle_d;
  logic                  sdi_q, sdi_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // Plain synchroniser chains for the asynchronous slave inputs.
  logic                  sdo_s1_q, sdo_s2_q;
  logic                  srdy_s1_q, srdy_s2_q;

  logic                  half_end;
  logic [BCW-1:0]        hdr_last;
  logic                  go_done;
  logic                  go_tmo;

  assign half_end = (phase_q == PCW'(CLK_DIV - 1));
  // Reads send only {write, addr}; writes append the data word.
  assign hdr_last = write_q ? BCW'(HDR_MAX - 1) : BCW'(ADDR_WIDTH);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bit_d         = bit_q;
    wait_d        = wait_q;
    shreg_d       = shreg_q;
    write_d       = write_q;
    rin_d         = rin_q;
    sclk_d        = sclk_q;
    sle_d         = sle_q;
    sdi_d         = sdi_q;
    busy_d        = busy_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    go_done       = 1'b0;
    go_tmo        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SHIFT_OUT;
          write_d = cmd_write;
          shreg_d = {cmd_write, cmd_addr, cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}}};
          sdi_d   = cmd_write;
          sle_d   = 1'b1;
          sclk_d  = 1'b0;
          phase_d = '0;
          bit_d   = '0;
          rin_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_SHIFT_OUT: begin
        phase_d = phase_q + PCW'(1);
        if (half_end) begin
          phase_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: either the frame header is complete or the next bit goes out.
            sclk_d = 1'b0;
            if (bit_q == hdr_last) begin
              state_d = S_WAIT_RDY;
              wait_d  = '0;
              sdi_d   = 1'b0;
            end else begin
              bit_d   = bit_q + BCW'(1);
              sdi_d   = shreg_q[HDR_MAX-2];
              shreg_d = {shreg_q[HDR_MAX-2:0], 1'b0};
            end
          end
        end
      end

      S_WAIT_RDY: begin
        // SRDY wins over a timeout landing in the same cycle.
        if (srdy_s2_q) begin
          if (write_q) begin
            go_done = 1'b1;
          end else begin
            state_d = S_SHIFT_IN;
            phase_d = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            sdi_d   = 1'b0;
          end
        end else if (wait_q == TCW'(TIMEOUT - 1)) begin
          go_done = 1'b1;
          go_tmo  = 1'b1;
        end else begin
          wait_d = wait_q + TCW'(1);
        end
      end

      S_SHIFT_IN: begin
        phase_d = phase_q + PCW'(1);
        // First high cycle of SCLK: capture the synchronised SDO, MSB arrives first.
        if (sclk_q && (phase_q == '0)) begin
          rin_d = {rin_q[DATA_WIDTH-2:0], sdo_s2_q};
        end
        if (half_end) begin
          phase_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == BCW'(DATA_WIDTH - 1)) begin
            go_done = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + BCW'(1);
          end
        end
      end

      S_DONE: begin
        // DONE doubles as the minimum inter-frame gap.
        phase_d = phase_q + PCW'(1);
        if (half_end) begin
          state_d = S_IDLE;
          phase_d = '0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_done) begin
      state_d       = S_DONE;
      phase_d       = '0;
      sle_d         = 1'b0;
      sclk_d        = 1'b0;
      sdi_d         = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = go_tmo;
      rsp_rdata_d   = (write_q || go_tmo) ? {DATA_WIDTH{1'b0}} : rin_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      bit_q         <= '0;
      wait_q        <= '0;
      shreg_q       <= '0;
      write_q       <= 1'b0;
      rin_q         <= '0;
      sclk_q        <= 1'b0;
      sle_q         <= 1'b0;
      sdi_q         <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      sdo_s1_q      <= 1'b0;
      sdo_s2_q      <= 1'b0;
      srdy_s1_q     <= 1'b0;
      srdy_s2_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      wait_q        <= wait_d;
      shreg_q       <= shreg_d;
      write_q       <= write_d;
      rin_q         <= rin_d;
      sclk_q        <= sclk_d;
      sle_q         <= sle_d;
      sdi_q         <= sdi_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      sdo_s1_q      <= mse_sdo;
      sdo_s2_q      <= sdo_s1_q;
      srdy_s1_q     <= mse_srdy;
      srdy_s2_q     <= srdy_s1_q;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mse_sclk    = sclk_q;
  assign mse_sle     = sle_q;
  assign mse_sdi     = sdi_q;

endmodule
